// File: rtl/store_queue_fwd.sv
// Multi-way store queue: in-order dispatch, ROB-tagged resolve, commit, DCache drain and
// same-cycle store-to-load forwarding. Define SQ_MERGE_FWD_EN to build loads from several stores.
module store_queue_fwd #(
   parameter int DEPTH  = 16,
   parameter int WAYS   = 4,
   parameter int ADDR_W = 16,
   parameter int ROB_W  = 5,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    except,
   input  logic [WAYS-1:0]         disp_en,
   input  logic [WAYS*2-1:0]       disp_size,
   input  logic [WAYS*ROB_W-1:0]   disp_rob,
   input  logic [WAYS-1:0]         res_valid,
   input  logic [WAYS*ROB_W-1:0]   res_rob,
   input  logic [WAYS*ADDR_W-1:0]  res_addr,
   input  logic [WAYS*32-1:0]      res_data,
   input  logic                    commit,
   output logic                    wr_valid,
   input  logic                    wr_ready,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [31:0]             wr_data,
   output logic [1:0]              wr_size,
   input  logic                    ld_q_valid,
   input  logic [ADDR_W-1:0]       ld_q_addr,
   input  logic [1:0]              ld_q_size,
   input  logic [PTR_W-1:0]        ld_q_tail,
   output logic                    fwd_hit,
   output logic [31:0]             fwd_data,
   output logic                    fwd_stall,
   output logic [PTR_W-1:0]        sq_tail,
   output logic [PTR_W:0]          num_free
);

   localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);

   logic [DEPTH-1:0]  valid_q, valid_d, cmtd_q, cmtd_d, addr_valid_q, addr_valid_d;
   logic [1:0]        size_q [DEPTH];
   logic [1:0]        size_d [DEPTH];
   logic [ROB_W-1:0]  rob_q  [DEPTH];
   logic [ROB_W-1:0]  rob_d  [DEPTH];
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [31:0]       data_q [DEPTH];
   logic [31:0]       data_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              wr_valid_q, wr_valid_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic [1:0]        wr_size_q, wr_size_d;

   logic [PTR_W:0]    disp_cnt, keep_cnt;
   logic              disp_ok, drain_fire;
   logic [PTR_W-1:0]  slot;

   function automatic logic [2:0] size_len(input logic [1:0] s);
      case (s)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   assign num_free = DEPTH_L - count_q;
   assign sq_tail  = tail_q;
   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign wr_size  = wr_size_q;

   // Commit and drain are applied before the exception flush so both survive it.
   always_comb begin
      valid_d      = valid_q;
      cmtd_d       = cmtd_q;
      addr_valid_d = addr_valid_q;
      size_d       = size_q;
      rob_d        = rob_q;
      addr_d       = addr_q;
      data_d       = data_q;
      head_d       = head_q;
      cmt_d        = cmt_q;
      tail_d       = tail_q;
      count_d      = count_q;
      keep_cnt     = '0;
      slot         = '0;
      drain_fire   = wr_valid_q & wr_ready;
      disp_cnt     = '0;
      for (int w = 0; w < WAYS; w++) disp_cnt = disp_cnt + (PTR_W+1)'(disp_en[w]);
      disp_ok = (disp_cnt <= num_free);

      if (commit) begin
         cmtd_d[cmt_q] = 1'b1;
         cmt_d         = cmt_q + 1'b1;
      end
      if (drain_fire) begin
         valid_d[head_q] = 1'b0;
         cmtd_d[head_q]  = 1'b0;
         head_d          = head_q + 1'b1;
      end

      if (except) begin
         for (int e = 0; e < DEPTH; e++) begin
            if (!cmtd_d[e]) valid_d[e] = 1'b0;
            keep_cnt = keep_cnt + (PTR_W+1)'(valid_d[e] & cmtd_d[e]);
         end
         tail_d  = cmt_d;
         count_d = keep_cnt;
      end else begin
         for (int w = 0; w < WAYS; w++) begin
            for (int e = 0; e < DEPTH; e++) begin
               if (res_valid[w] && valid_q[e] && (rob_q[e] == res_rob[w*ROB_W +: ROB_W])) begin
                  addr_d[e]       = res_addr[w*ADDR_W +: ADDR_W];
                  data_d[e]       = res_data[w*32 +: 32];
                  addr_valid_d[e] = 1'b1;
               end
            end
         end
         if (disp_ok) begin
            for (int w = 0; w < WAYS; w++) begin
               if (disp_en[w]) begin
                  slot               = tail_q + PTR_W'(w);
                  valid_d[slot]      = 1'b1;
                  cmtd_d[slot]       = 1'b0;
                  addr_valid_d[slot] = 1'b0;
                  size_d[slot]       = disp_size[w*2 +: 2];
                  rob_d[slot]        = disp_rob[w*ROB_W +: ROB_W];
               end
            end
            tail_d = tail_q + disp_cnt[PTR_W-1:0];
         end
         count_d = count_q + (disp_ok ? disp_cnt : '0) - (PTR_W+1)'(drain_fire);
      end

      // Write port is registered from the next-state head entry.
      wr_valid_d = valid_d[head_d] & cmtd_d[head_d];
      wr_addr_d  = addr_d[head_d];
      wr_data_d  = data_d[head_d];
      wr_size_d  = size_d[head_d];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q      <= '0;
         cmtd_q       <= '0;
         addr_valid_q <= '0;
         for (int e = 0; e < DEPTH; e++) begin
            size_q[e] <= '0;
            rob_q[e]  <= '0;
            addr_q[e] <= '0;
            data_q[e] <= '0;
         end
         head_q     <= '0;
         cmt_q      <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_size_q  <= '0;
      end else begin
         valid_q      <= valid_d;
         cmtd_q       <= cmtd_d;
         addr_valid_q <= addr_valid_d;
         size_q       <= size_d;
         rob_q        <= rob_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         head_q       <= head_d;
         cmt_q        <= cmt_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         wr_valid_q   <= wr_valid_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         wr_size_q    <= wr_size_d;
      end
   end

   always @(posedge clock) begin
      if (reset && !except && (disp_cnt != '0)) assert (disp_ok);
      if (reset && commit) assert (valid_q[cmt_q] && addr_valid_q[cmt_q]);
   end

   logic [PTR_W-1:0]  fw_dist, fw_idx;
   logic [ADDR_W:0]   ld_lo, ld_hi, st_lo, st_hi;
   logic [2:0]        ld_len;
`ifdef SQ_MERGE_FWD_EN
   logic [3:0]        byte_have, need_mask;
   logic [31:0]       byte_data;
   logic              any_unres;
   logic [ADDR_W:0]   b_addr, b_off;
`else
   logic [ADDR_W:0]   sh;
   logic [31:0]       ld_mask;
`endif

   // Entries are walked oldest to youngest so the youngest relevant store has the last word.
   always_comb begin
      fwd_hit   = 1'b0;
      fwd_stall = 1'b0;
      fwd_data  = '0;
      ld_len    = size_len(ld_q_size);
      ld_lo     = {1'b0, ld_q_addr};
      ld_hi     = ld_lo + (ADDR_W+1)'(ld_len);
      fw_dist   = ld_q_tail - head_q;
      fw_idx    = '0;
      st_lo     = '0;
      st_hi     = '0;
`ifdef SQ_MERGE_FWD_EN
      byte_have = '0;
      byte_data = '0;
      any_unres = 1'b0;
      b_addr    = '0;
      b_off     = '0;
      need_mask = (ld_len == 3'd1) ? 4'b0001 : (ld_len == 3'd2) ? 4'b0011 : 4'b1111;
`else
      sh        = '0;
      ld_mask   = (ld_len == 3'd1) ? 32'h0000_00FF : (ld_len == 3'd2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
`endif
      if (ld_q_valid) begin
         for (int k = 0; k < DEPTH; k++) begin
            fw_idx = head_q + PTR_W'(k);
            st_lo  = {1'b0, addr_q[fw_idx]};
            st_hi  = st_lo + (ADDR_W+1)'(size_len(size_q[fw_idx]));
            if ((PTR_W'(k) < fw_dist) && valid_q[fw_idx]) begin
`ifdef SQ_MERGE_FWD_EN
               if (!addr_valid_q[fw_idx]) begin
                  any_unres = 1'b1;
               end else begin
                  for (int b = 0; b < 4; b++) begin
                     b_addr = ld_lo + (ADDR_W+1)'(b);
                     if ((3'(b) < ld_len) && (st_lo <= b_addr) && (b_addr < st_hi)) begin
                        b_off             = b_addr - st_lo;
                        byte_have[b]      = 1'b1;
                        byte_data[8*b +: 8] = data_q[fw_idx][{b_off[1:0], 3'b000} +: 8];
                     end
                  end
               end
`else
               if (!addr_valid_q[fw_idx]) begin
                  fwd_hit   = 1'b0;
                  fwd_stall = 1'b1;
                  fwd_data  = '0;
               end else if ((st_lo < ld_hi) && (ld_lo < st_hi)) begin
                  if ((st_lo <= ld_lo) && (ld_hi <= st_hi)) begin
                     sh        = ld_lo - st_lo;
                     fwd_hit   = 1'b1;
                     fwd_stall = 1'b0;
                     fwd_data  = (data_q[fw_idx] >> {sh[1:0], 3'b000}) & ld_mask;
                  end else begin
                     fwd_hit   = 1'b0;
                     fwd_stall = 1'b1;
                     fwd_data  = '0;
                  end
               end
`endif
            end
         end
`ifdef SQ_MERGE_FWD_EN
         if (any_unres) begin
            fwd_stall = 1'b1;
         end else if (byte_have != 4'b0000) begin
            if (byte_have == need_mask) begin
               fwd_hit  = 1'b1;
               fwd_data = byte_data;
            end else begin
               fwd_stall = 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_store_queue_fwd.sv
// Bench for store_queue_fwd: directed steps then random traffic against a queue-based model.
// Expected forwarding results follow SQ_MERGE_FWD_EN when it is defined.
module tb_store_queue_fwd;

   localparam int DEPTH = 16;
   localparam int WAYS  = 4;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         except, commit, wr_ready, ld_q_valid;
   logic [3:0]   disp_en, res_valid;
   logic [7:0]   disp_size;
   logic [19:0]  disp_rob, res_rob;
   logic [63:0]  res_addr;
   logic [127:0] res_data;
   logic [15:0]  ld_q_addr;
   logic [1:0]   ld_q_size;
   logic [3:0]   ld_q_tail;
   logic         wr_valid, fwd_hit, fwd_stall;
   logic [15:0]  wr_addr;
   logic [31:0]  wr_data, fwd_data;
   logic [1:0]   wr_size;
   logic [3:0]   sq_tail;
   logic [4:0]   num_free;

   store_queue_fwd dut (
      .clock(clock), .reset(reset), .except(except),
      .disp_en(disp_en), .disp_size(disp_size), .disp_rob(disp_rob),
      .res_valid(res_valid), .res_rob(res_rob), .res_addr(res_addr), .res_data(res_data),
      .commit(commit), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_size(wr_size), .ld_q_valid(ld_q_valid), .ld_q_addr(ld_q_addr),
      .ld_q_size(ld_q_size), .ld_q_tail(ld_q_tail), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .fwd_stall(fwd_stall), .sq_tail(sq_tail), .num_free(num_free)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [4:0]  rob;
      logic [1:0]  size;
      int          addr;
      logic [31:0] data;
      bit          res;
      bit          cmt;
   } st_t;

   st_t mq[$];
   int  m_head, m_tail, m_ncmt;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  rob_ctr = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int len_of(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit rob_busy(input logic [4:0] r);
      foreach (mq[i]) if (mq[i].rob == r) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_head = 0;
      m_tail = 0;
      m_ncmt = 0;
   endtask

   // Applies the inputs present at a rising edge to the model.
   task automatic model_edge();
      bit  drain;
      int  n, free_before;
      st_t e;
      drain       = wr_ready && (mq.size() > 0) && mq[0].cmt;
      free_before = DEPTH - mq.size();
      if (commit) begin
         e = mq[m_ncmt]; e.cmt = 1'b1; mq[m_ncmt] = e;
         m_ncmt++;
      end
      if (drain) begin
         mq.delete(0);
         m_head = (m_head + 1) % DEPTH;
         m_ncmt--;
      end
      if (except) begin
         while (mq.size() > m_ncmt) mq.delete(mq.size() - 1);
         m_tail = (m_head + m_ncmt) % DEPTH;
      end else begin
         for (int w = 0; w < WAYS; w++) begin
            if (res_valid[w]) begin
               for (int i = 0; i < mq.size(); i++) begin
                  if (mq[i].rob == res_rob[w*5 +: 5]) begin
                     e = mq[i];
                     e.addr = int'(res_addr[w*16 +: 16]);
                     e.data = res_data[w*32 +: 32];
                     e.res  = 1'b1;
                     mq[i]  = e;
                  end
               end
            end
         end
         n = $countones(disp_en);
         if (n <= free_before) begin
            for (int w = 0; w < n; w++) begin
               e.rob = disp_rob[w*5 +: 5]; e.size = disp_size[w*2 +: 2];
               e.addr = 0; e.data = '0; e.res = 1'b0; e.cmt = 1'b0;
               mq.push_back(e);
            end
            m_tail = (m_tail + n) % DEPTH;
         end
      end
   endtask

   task automatic model_fwd(output bit hit, output bit stall, output logic [31:0] data);
      int  n_old, len, la, slen, got;
      bit  found;
      st_t s;
      hit = 1'b0; stall = 1'b0; data = '0;
      if (!ld_q_valid) return;
      len   = len_of(ld_q_size);
      la    = int'(ld_q_addr);
      n_old = (int'(ld_q_tail) - m_head + DEPTH) % DEPTH;
      if (n_old > mq.size()) n_old = mq.size();
`ifdef SQ_MERGE_FWD_EN
      for (int p = 0; p < n_old; p++) if (!mq[p].res) begin stall = 1'b1; return; end
      got = 0;
      for (int b = 0; b < len; b++) begin
         found = 1'b0;
         for (int p = n_old - 1; p >= 0 && !found; p--) begin
            s = mq[p]; slen = len_of(s.size);
            if (la + b >= s.addr && la + b < s.addr + slen) begin
               data[8*b +: 8] = s.data[8*(la + b - s.addr) +: 8];
               found = 1'b1;
               got++;
            end
         end
      end
      if (got == len) hit = 1'b1;
      else if (got > 0) begin stall = 1'b1; data = '0; end
`else
      got = 0;
      for (int p = n_old - 1; p >= 0; p--) begin
         s = mq[p]; slen = len_of(s.size);
         if (!s.res) begin stall = 1'b1; return; end
         if (s.addr < la + len && la < s.addr + slen) begin
            if (s.addr <= la && la + len <= s.addr + slen) begin
               hit = 1'b1;
               for (int b = 0; b < len; b++) data[8*b +: 8] = s.data[8*(la + b - s.addr) +: 8];
            end else begin
               stall = 1'b1;
            end
            return;
         end
      end
`endif
   endtask

   task automatic check_state();
      bit ev;
      chk("sq_tail", 32'(sq_tail), 32'(m_tail));
      chk("num_free", 32'(num_free), 32'(DEPTH - mq.size()));
      ev = (mq.size() > 0) && mq[0].cmt;
      chk("wr_valid", 32'(wr_valid), 32'(ev));
      if (ev) begin
         chk("wr_addr", 32'(wr_addr), 32'(mq[0].addr));
         chk("wr_data", wr_data, mq[0].data);
         chk("wr_size", 32'(wr_size), 32'(mq[0].size));
      end
   endtask

   // Called just after a rising edge: checks forwarding, crosses the next edge, checks state.
   task automatic cycle();
      bit          eh, es;
      logic [31:0] ed;
      #1;
      model_fwd(eh, es, ed);
      chk("fwd_hit", 32'(fwd_hit), 32'(eh));
      chk("fwd_stall", 32'(fwd_stall), 32'(es));
      chk("fwd_data", fwd_data, ed);
      @(posedge clock);
      model_edge();
      #1;
      check_state();
   endtask

   task automatic idle();
      except = 1'b0; commit = 1'b0; wr_ready = 1'b0; ld_q_valid = 1'b0;
      disp_en = '0; disp_size = '0; disp_rob = '0;
      res_valid = '0; res_rob = '0; res_addr = '0; res_data = '0;
      ld_q_addr = '0; ld_q_size = '0; ld_q_tail = '0;
   endtask

   task automatic set_disp(input int w, input logic [4:0] rob, input logic [1:0] sz);
      disp_en[w] = 1'b1;
      disp_rob[w*5 +: 5] = rob;
      disp_size[w*2 +: 2] = sz;
   endtask

   task automatic set_res(input int w, input logic [4:0] rob, input logic [15:0] a, input logic [31:0] d);
      res_valid[w] = 1'b1;
      res_rob[w*5 +: 5] = rob;
      res_addr[w*16 +: 16] = a;
      res_data[w*32 +: 32] = d;
   endtask

   task automatic set_load(input logic [15:0] a, input logic [1:0] sz, input logic [3:0] t);
      ld_q_valid = 1'b1; ld_q_addr = a; ld_q_size = sz; ld_q_tail = t;
   endtask

   initial begin
      int n, w, free;
      idle();
      model_reset();
      @(posedge clock); @(posedge clock); #1;
      chk("rst_num_free", 32'(num_free), 32'd16);
      chk("rst_sq_tail", 32'(sq_tail), 32'd0);
      chk("rst_wr_valid", 32'(wr_valid), 32'd0);
      chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
      chk("rst_fwd_stall", 32'(fwd_stall), 32'd0);
      chk("rst_fwd_data", fwd_data, 32'd0);
      reset = 1'b1;

      // Walk the pointers to 14 and empty the queue again.
      for (int g = 0; g < 4; g++) begin
         idle();
         n = (g == 3) ? 2 : 4;
         for (int i = 0; i < n; i++) set_disp(i, 5'(10 + 4*g + i), 2'd2);
         cycle();
      end
      for (int g = 0; g < 4; g++) begin
         idle();
         n = (g == 3) ? 2 : 4;
         for (int i = 0; i < n; i++) set_res(i, 5'(10 + 4*g + i), 16'(16'h0400 + 16'(16*g + 4*i)), $urandom);
         cycle();
      end
      for (int i = 0; i < 14; i++) begin
         idle(); commit = 1'b1; wr_ready = 1'b1;
         cycle();
      end
      for (int i = 0; i < 40 && mq.size() > 0; i++) begin
         idle(); wr_ready = 1'b1;
         cycle();
      end
      chk("fill_empty", 32'(num_free), 32'd16);
      chk("fill_tail", 32'(sq_tail), 32'd14);

      // Four stores across the wrap point.
      idle();
      for (int i = 0; i < 4; i++) set_disp(i, 5'(i + 1), 2'd2);
      cycle();
      chk("wrap_tail", 32'(sq_tail), 32'd2);
      chk("wrap_free", 32'(num_free), 32'd12);
      idle();
      set_res(0, 5'd1, 16'h0200, 32'h1111_1111);
      set_res(1, 5'd2, 16'h0204, 32'h2222_2222);
      set_res(2, 5'd3, 16'h0100, 32'hDEAD_BEEF);
      cycle();

      idle(); set_load(16'h0102, 2'd0, 4'd1); #1;
      chk("fwd_byte_hit", 32'(fwd_hit), 32'd1);
      chk("fwd_byte_data", fwd_data, 32'h0000_00AD);
      chk("fwd_byte_nostall", 32'(fwd_stall), 32'd0);
      cycle();

      idle(); set_load(16'h0102, 2'd0, 4'd2); #1;
      chk("fwd_unres_stall", 32'(fwd_stall), 32'd1);
      chk("fwd_unres_nohit", 32'(fwd_hit), 32'd0);
      cycle();

      idle();
      set_res(0, 5'd4, 16'h0300, 32'h4444_4444);
      set_disp(0, 5'd5, 2'd0);
      set_disp(1, 5'd6, 2'd0);
      cycle();
      idle();
      set_res(0, 5'd5, 16'h0101, 32'h0000_0022);
      set_res(1, 5'd6, 16'h0100, 32'h0000_0011);
      cycle();

      idle(); set_load(16'h0100, 2'd1, 4'd4); #1;
`ifdef SQ_MERGE_FWD_EN
      chk("merge_hit", 32'(fwd_hit), 32'd1);
      chk("merge_data", fwd_data, 32'h0000_2211);
`else
      chk("partial_stall", 32'(fwd_stall), 32'd1);
      chk("partial_nohit", 32'(fwd_hit), 32'd0);
`endif
      cycle();

      // Commit two, stall the DCache, then flush the rest.
      idle(); commit = 1'b1; cycle();
      idle(); commit = 1'b1; cycle();
      for (int i = 0; i < 3; i++) begin
         idle(); cycle();
         chk("hold_valid", 32'(wr_valid), 32'd1);
         chk("hold_addr", 32'(wr_addr), 32'h0200);
         chk("hold_data", wr_data, 32'h1111_1111);
      end
      idle(); except = 1'b1; cycle();
      chk("exc_free", 32'(num_free), 32'd14);
      chk("exc_tail", 32'(sq_tail), 32'd0);
      chk("exc_wr_addr", 32'(wr_addr), 32'h0200);
      idle(); wr_ready = 1'b1; cycle();
      chk("drain1_addr", 32'(wr_addr), 32'h0204);
      chk("drain1_data", wr_data, 32'h2222_2222);
      idle(); wr_ready = 1'b1; cycle();
      chk("drain2_free", 32'(num_free), 32'd16);
      chk("drain2_valid", 32'(wr_valid), 32'd0);

      // Reset in the middle of activity.
      idle();
      for (int i = 0; i < 3; i++) set_disp(i, 5'(7 + i), 2'd2);
      cycle();
      idle();
      for (int i = 0; i < 3; i++) set_res(i, 5'(7 + i), 16'(16'h0110 + 16'(4*i)), $urandom);
      cycle();
      idle(); commit = 1'b1; cycle();
      chk("pre_rst_valid", 32'(wr_valid), 32'd1);
      chk("pre_rst_free", 32'(num_free), 32'd13);
      idle(); set_load(16'h0110, 2'd2, 4'd1);
      reset = 1'b0;
      #1;
      model_reset();
      chk("mrst_num_free", 32'(num_free), 32'd16);
      chk("mrst_wr_valid", 32'(wr_valid), 32'd0);
      chk("mrst_sq_tail", 32'(sq_tail), 32'd0);
      chk("mrst_fwd_hit", 32'(fwd_hit), 32'd0);
      chk("mrst_fwd_stall", 32'(fwd_stall), 32'd0);
      chk("mrst_fwd_data", fwd_data, 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      idle();

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         idle();
         wr_ready = ($urandom_range(0, 3) != 0);
         except   = ($urandom_range(0, 39) == 0);
         free = DEPTH - mq.size();
         n = $urandom_range(0, (free < WAYS) ? free : WAYS);
         for (int i = 0; i < n; i++) begin
            do rob_ctr = (rob_ctr + 1) % 32; while (rob_busy(5'(rob_ctr)));
            set_disp(i, 5'(rob_ctr), 2'($urandom_range(0, 2)));
         end
         w = 0;
         for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].res && w < WAYS && $urandom_range(0, 1) == 1) begin
               set_res(w, mq[i].rob, 16'(16'h0100 + 16'($urandom_range(0, 12))), $urandom);
               w++;
            end
         end
         if (m_ncmt < mq.size() && mq[m_ncmt].res && $urandom_range(0, 1) == 1) commit = 1'b1;
         if ($urandom_range(0, 3) != 0)
            set_load(16'(16'h0100 + 16'($urandom_range(0, 12))), 2'($urandom_range(0, 2)),
                     4'((m_head + $urandom_range(0, mq.size())) % DEPTH));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
